pwm_peripheral: RTL and testbench

Output stage that converts the five control registers written over SPI into the 16 user output pins. Each pin is independently forced low, driven static high, or driven by a shared 8-bit PWM waveform whose duty cycle comes from the duty-cycle register. The block sits directly downstream of the SPI register file and drives the chip's uo_out/uio_out pins through the top level.

---
 rtl/pwm_peripheral.sv | 67 ++++++
 tb/tb_pwm_peripheral.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - shared 8-bit PWM driving 16 pins with per-pin off/static/pwm modes
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [15:0] prescaler_q, prescaler_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [7:0]  duty_shadow_q, duty_shadow_d;
    logic [15:0] out_q, out_d;
    logic        period_start_q, period_start_d;

    logic        tick;
    logic        wrap;
    logic        pwm_level;
    logic [15:0] en_out;
    logic [15:0] en_pwm;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Counting, duty shadowing at period boundary, and per-pin output selection.
    // With CLK_DIV = 1 the prescaler stays at 0, so tick is permanently high.
    always_comb begin
        tick           = (prescaler_q == DIV_LAST);
        wrap           = tick && (pwm_cnt_q == 8'hFF);
        prescaler_d    = tick ? 16'd0 : prescaler_q + 16'd1;
        pwm_cnt_d      = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        duty_shadow_d  = wrap ? pwm_duty_cycle : duty_shadow_q;
        // 0xFF is special-cased so full duty has no single low count per period.
        pwm_level      = (duty_shadow_q == 8'hFF) || (pwm_cnt_q < duty_shadow_q);
        out_d          = en_out & (~en_pwm | {16{pwm_level}});
        period_start_d = wrap;
    end

    // State registers; asynchronous reset drives the pins low immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q    <= 16'd0;
            pwm_cnt_q      <= 8'd0;
            duty_shadow_q  <= 8'd0;
            out_q          <= 16'd0;
            period_start_q <= 1'b0;
        end else begin
            prescaler_q    <= prescaler_d;
            pwm_cnt_q      <= pwm_cnt_d;
            duty_shadow_q  <= duty_shadow_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb/tb_pwm_peripheral.sv - randomized and directed checks of pwm_peripheral against a cycle-count model
module tb_pwm_peripheral;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] en_o = 16'h0;
    logic [15:0] en_p = 16'h0;
    logic [7:0]  duty = 8'h0;
    logic [15:0] out13, out2;
    logic        ps13, ps2;

    int n_cmp = 0;
    int n_fail = 0;
    int model_mm = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(13)) dut13 (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(en_o[7:0]), .en_reg_out_15_8(en_o[15:8]),
        .en_reg_pwm_7_0(en_p[7:0]), .en_reg_pwm_15_8(en_p[15:8]),
        .pwm_duty_cycle(duty), .out(out13), .period_start(ps13)
    );

    pwm_peripheral #(.CLK_DIV(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .en_reg_out_7_0(en_o[7:0]), .en_reg_out_15_8(en_o[15:8]),
        .en_reg_pwm_7_0(en_p[7:0]), .en_reg_pwm_15_8(en_p[15:8]),
        .pwm_duty_cycle(duty), .out(out2), .period_start(ps2)
    );

    // Reference model: position in the PWM period is derived from the number of
    // clock edges since reset release; duty is latched per period at the boundary.
    int          divs [2] = '{13, 2};
    int          m_cyc [2];
    logic [7:0]  m_sh [2];
    logic [15:0] m_out [2];
    logic        m_ps [2];

    function automatic logic model_level(int cyc, int d, logic [7:0] sh);
        int cnt;
        cnt = (cyc / d) % 256;
        if (sh == 8'hFF) return 1'b1;
        return (cnt < int'(sh));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 2; j++) begin
                m_cyc[j] = 0;
                m_sh[j]  = 8'h00;
                m_out[j] <= 16'h0;
                m_ps[j]  <= 1'b0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                logic        lvl;
                logic [15:0] nxt;
                logic        boundary;
                lvl = model_level(m_cyc[j], divs[j], m_sh[j]);
                for (int i = 0; i < 16; i++) begin
                    if (!en_o[i])      nxt[i] = 1'b0;
                    else if (!en_p[i]) nxt[i] = 1'b1;
                    else               nxt[i] = lvl;
                end
                boundary = (m_cyc[j] % (256 * divs[j])) == (256 * divs[j] - 1);
                m_out[j] <= nxt;
                m_ps[j]  <= boundary;
                if (boundary) m_sh[j] = duty;
                m_cyc[j] = m_cyc[j] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && (out13 !== m_out[0] || ps13 !== m_ps[0] ||
                      out2 !== m_out[1] || ps2 !== m_ps[1]))
            model_mm = model_mm + 1;
    end

    task automatic test_reset();
        int n;
        int mm0;
        en_o = 16'hFFFF; en_p = 16'h0000; duty = 8'h80;
        @(negedge clk); rst_n = 1'b1;
        mm0 = model_mm;
        repeat (1000) @(negedge clk);
        n_cmp++;
        if (out13 !== 16'hFFFF || out2 !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL reset_pre: out13=%h out2=%h required ffff", out13, out2);
        end
        @(posedge clk); #3 rst_n = 1'b0; #1;
        n_cmp++;
        if ({out13, ps13, out2, ps2} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_async: out13=%h ps13=%b out2=%h ps2=%b required all 0", out13, ps13, out2, ps2);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (ps13 !== 1'b1 && n < 4000);
        n_cmp++;
        if (n !== 3328) begin
            n_fail++;
            $display("FAIL reset_restart: first period_start after %0d cycles, required 3328", n);
        end
        n_cmp++;
        if (model_mm - mm0 !== 0) begin
            n_fail++;
            $display("FAIL reset_model: %0d mismatching cycles, required 0", model_mm - mm0);
        end
    endtask

    task automatic test_first_period();
        int first13, first2, low13, low2;
        @(negedge clk);
        rst_n = 1'b0; duty = 8'hFF; en_o = 16'hFFFF; en_p = 16'hFFFF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        first13 = -1; first2 = -1; low13 = 0; low2 = 0;
        for (int n = 1; n <= 2 * 3328 + 10; n++) begin
            @(negedge clk);
            if (first13 < 0 && out13[0] === 1'b1) first13 = n;
            else if (first13 >= 0 && out13 !== 16'hFFFF) low13++;
            if (first2 < 0 && out2[0] === 1'b1) first2 = n;
            else if (first2 >= 0 && out2 !== 16'hFFFF) low2++;
        end
        n_cmp++;
        if (first13 - 1 !== 3328) begin
            n_fail++;
            $display("FAIL first_low13: low for %0d cycles, required 3328", first13 - 1);
        end
        n_cmp++;
        if (first2 - 1 !== 512) begin
            n_fail++;
            $display("FAIL first_low2: low for %0d cycles, required 512", first2 - 1);
        end
        n_cmp++;
        if (low13 !== 0 || low2 !== 0) begin
            n_fail++;
            $display("FAIL first_high: low cycles after start %0d/%0d, required 0/0", low13, low2);
        end
    endtask

    task automatic test_static();
        @(negedge clk);
        en_o = 16'h00FF; en_p = 16'h0000; duty = 8'h80;
        @(negedge clk);
        n_cmp++;
        if (out13 !== 16'h00FF || out2 !== 16'h00FF) begin
            n_fail++;
            $display("FAIL static_high: out13=%h out2=%h required 00ff", out13, out2);
        end
        en_o = 16'h0000; en_p = 16'h00FF;
        @(negedge clk);
        n_cmp++;
        if (out13[7:0] !== 8'h00 || out2[7:0] !== 8'h00) begin
            n_fail++;
            $display("FAIL static_enable: out13=%h out2=%h required low byte 00", out13, out2);
        end
    endtask

    task automatic test_duty_sweep();
        logic [7:0] duties [5] = '{8'h00, 8'h01, 8'h80, 8'hFE, 8'hFF};
        int         expect_hi [5] = '{0, 2, 256, 508, 512};
        int         hi, nonuni, n;
        en_o = 16'hFFFF; en_p = 16'hFFFF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            duty = duties[k];
            n = 0;
            do begin @(negedge clk); n++; end while (ps2 !== 1'b1 && n < 1100);
            hi = 0; nonuni = 0;
            repeat (512) begin
                @(negedge clk);
                if (out2[0] === 1'b1) hi++;
                if (out2 !== 16'h0000 && out2 !== 16'hFFFF) nonuni++;
            end
            n_cmp++;
            if (hi !== expect_hi[k] || n >= 1100) begin
                n_fail++;
                $display("FAIL sweep_%h: high %0d cycles (wait %0d), required %0d", duties[k], hi, n, expect_hi[k]);
            end
            n_cmp++;
            if (nonuni !== 0) begin
                n_fail++;
                $display("FAIL sweep_align_%h: %0d unaligned cycles, required 0", duties[k], nonuni);
            end
        end
    endtask

    task automatic test_shadowing();
        int hi_a, hi_b, n;
        en_o = 16'hFFFF; en_p = 16'hFFFF;
        @(negedge clk);
        duty = 8'h40;
        n = 0;
        do begin @(negedge clk); n++; end while (ps13 !== 1'b1 && n < 3400);
        hi_a = 0; hi_b = 0;
        for (int i = 1; i <= 6656; i++) begin
            @(negedge clk);
            if (i == 131) duty = 8'hC0;
            if (out13[0] === 1'b1) begin
                if (i <= 3328) hi_a++;
                else hi_b++;
            end
        end
        n_cmp++;
        if (hi_a !== 832 || n >= 3400) begin
            n_fail++;
            $display("FAIL shadow_current: high %0d cycles, required 832", hi_a);
        end
        n_cmp++;
        if (hi_b !== 2496) begin
            n_fail++;
            $display("FAIL shadow_next: high %0d cycles, required 2496", hi_b);
        end
    endtask

    task automatic test_period_start();
        int   last, pulses, bad_space, bad_width, bad_align;
        logic prev_ps, prev_out;
        en_o = 16'hFFFF; en_p = 16'hFFFF; duty = 8'hC0;
        last = -1; pulses = 0; bad_space = 0; bad_width = 0; bad_align = 0;
        prev_ps = 1'b0; prev_out = 1'b0;
        for (int c = 0; c < 3 * 3328 + 5; c++) begin
            @(negedge clk);
            if (prev_ps) begin
                if (ps13 === 1'b1) bad_width++;
                if (!(prev_out === 1'b0 && out13[0] === 1'b1)) bad_align++;
            end
            if (ps13 === 1'b1) begin
                if (last >= 0 && c - last != 3328) bad_space++;
                last = c;
                pulses++;
            end
            prev_ps = ps13;
            prev_out = out13[0];
        end
        n_cmp++;
        if (pulses < 3) begin
            n_fail++;
            $display("FAIL ps_count: %0d pulses, required at least 3", pulses);
        end
        n_cmp++;
        if (bad_space !== 0 || bad_width !== 0) begin
            n_fail++;
            $display("FAIL ps_spacing: bad spacing %0d, bad width %0d, required 0/0", bad_space, bad_width);
        end
        n_cmp++;
        if (bad_align !== 0) begin
            n_fail++;
            $display("FAIL ps_align: %0d pulses not followed by pin rise, required 0", bad_align);
        end
    endtask

    task automatic test_random();
        int mm0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            en_o = 16'($urandom);
            en_p = 16'($urandom);
            duty = 8'($urandom);
            mm0 = model_mm;
            repeat ($urandom_range(100, 1200)) @(negedge clk);
            n_cmp++;
            if (model_mm - mm0 !== 0) begin
                n_fail++;
                $display("FAIL random_%0d: %0d cycles differ from model (out13=%h exp=%h), required 0",
                         k, model_mm - mm0, out13, m_out[0]);
            end
        end
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_period();
        test_static();
        test_duty_sweep();
        test_shadowing();
        test_period_start();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
